// File: rtl/xm23_alu_pkg.sv
// ---------------------------------------------------------------------------
// xm23_alu_pkg
//   Shared definitions for the XM23 ALU slice:
//     - 5-bit operation codes (alu_op[4:0]) ADD..SXT
//     - PSW bit positions (C, Z, N, SLP, V)
//     - position of the byte-mode select bit inside alu_op
//     - merge_byte(): keeps the destination high byte for byte-mode results
// ---------------------------------------------------------------------------
package xm23_alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 6;

  // Operation codes carried on alu_op[4:0]; codes 17..31 are unsupported
  // and pass the destination through with flags untouched.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDC = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SUBC = 5'd3;
  localparam logic [4:0] OP_DADD = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_BIT  = 5'd9;
  localparam logic [4:0] OP_BIC  = 5'd10;
  localparam logic [4:0] OP_BIS  = 5'd11;
  localparam logic [4:0] OP_MOV  = 5'd12;
  localparam logic [4:0] OP_SRA  = 5'd13;
  localparam logic [4:0] OP_RRC  = 5'd14;
  localparam logic [4:0] OP_SWPB = 5'd15;
  localparam logic [4:0] OP_SXT  = 5'd16;

  // PSW bit indices
  localparam int PSW_C   = 0;
  localparam int PSW_Z   = 1;
  localparam int PSW_N   = 2;
  localparam int PSW_SLP = 3;
  localparam int PSW_V   = 4;

  // alu_op bit selecting byte (1) or word (0) operation
  localparam int BYTE_BIT = 5;

  // In byte mode only the low byte is produced; the high byte of the
  // destination passes through unchanged.
  function automatic logic [DATA_W-1:0] merge_byte(
    input logic              byte_mode,
    input logic [DATA_W-1:0] dst,
    input logic [DATA_W-1:0] val
  );
    return byte_mode ? {dst[15:8], val[7:0]} : val;
  endfunction

endpackage : xm23_alu_pkg

// File: rtl/xm23_alu_if.sv
// ---------------------------------------------------------------------------
// xm23_alu_if
//   Operand / control / result bundle between the XM23 control unit and ALU.
//     d_bus      destination operand          (master -> slave)
//     s_bus      source operand               (master -> slave)
//     alu_op     [4:0] op code, [5] byte mode (master -> slave)
//     psw_in     current PSW                  (master -> slave)
//     alu_E      result/PSW load enable       (master -> slave)
//     psw_update write computed flags         (master -> slave)
//     alu_out    registered result            (slave -> master)
//     psw_out    registered PSW               (slave -> master)
//   modport master: control unit side; modport slave: ALU side.
// ---------------------------------------------------------------------------
interface xm23_alu_if;
  import xm23_alu_pkg::*;

  logic [DATA_W-1:0] d_bus;
  logic [DATA_W-1:0] s_bus;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] psw_in;
  logic              alu_E;
  logic              psw_update;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] psw_out;

  modport master (
    output d_bus, s_bus, alu_op, psw_in, alu_E, psw_update,
    input  alu_out, psw_out
  );

  modport slave (
    input  d_bus, s_bus, alu_op, psw_in, alu_E, psw_update,
    output alu_out, psw_out
  );

endinterface : xm23_alu_if

// File: rtl/xm23_alu_bcd_adder.sv
// ---------------------------------------------------------------------------
// xm23_bcd_adder
//   Four-digit packed BCD adder with carry in/out. Each nibble adds its two
//   digits plus the incoming carry; a nibble sum above 9 is corrected by +6
//   and produces a carry into the next nibble. Non-BCD digits follow the
//   same rule without any error indication.
//   Ports:
//     a_i    [15:0] first operand (4 packed digits)
//     b_i    [15:0] second operand
//     c_i           carry in
//     byte_i        1: carry out taken after the second digit
//     sum_o  [15:0] corrected sum (upper digits meaningless in byte mode)
//     c_o           decimal carry out
//   Built only when ALU_DADD_EN is defined.
// ---------------------------------------------------------------------------
module xm23_bcd_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  input  logic        byte_i,
  output logic [15:0] sum_o,
  output logic        c_o
);

  logic [4:0] carry;

  assign carry[0] = c_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [4:0] raw;
    logic       adj;

    // Max raw sum is 15+15+1 = 31, so 5 bits suffice before correction.
    assign raw = {1'b0, a_i[4*gi +: 4]} + {1'b0, b_i[4*gi +: 4]} + {4'd0, carry[gi]};
    assign adj = (raw > 5'd9);
    assign sum_o[4*gi +: 4] = raw[3:0] + (adj ? 4'd6 : 4'd0);
    assign carry[gi+1] = adj;
  end

  assign c_o = byte_i ? carry[2] : carry[4];

endmodule : xm23_bcd_adder

// File: rtl/xm23_alu.sv
// ---------------------------------------------------------------------------
// xm23_alu
//   XM23 arithmetic/logic unit. Combines destination (d_bus) and source
//   (s_bus) per alu_op, producing a registered 16-bit result and PSW with
//   one cycle of latency.
//   Ports:
//     clk_i    system clock, all state on rising edge
//     srst_i   synchronous active-high reset (wins over alu_E)
//     alu_if   xm23_alu_if.slave: d_bus, s_bus, alu_op, psw_in, alu_E,
//              psw_update in; alu_out, psw_out out
//   Build option:
//     ALU_DADD_EN  when defined, op 4 performs packed BCD add; otherwise
//                  op 4 passes d through with flags unchanged and no BCD
//                  logic is built.
// ---------------------------------------------------------------------------
module xm23_alu
  import xm23_alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       srst_i,
  xm23_alu_if.slave  alu_if
);

  logic [DATA_W-1:0] d_val;
  logic [DATA_W-1:0] s_val;
  logic [DATA_W-1:0] psw_val;
  logic [4:0]        op;
  logic              byte_mode;
  logic              c_in;

  assign d_val   = alu_if.d_bus;
  assign s_val   = alu_if.s_bus;
  assign psw_val = alu_if.psw_in;
  assign op      = alu_if.alu_op[4:0];
  assign c_in    = psw_val[PSW_C];

  // SWPB and SXT are word-only regardless of the byte-mode bit.
  assign byte_mode = alu_if.alu_op[BYTE_BIT] && (op != OP_SWPB) && (op != OP_SXT);

  // -------------------------------------------------------------------------
  // Shared adder for ADD/ADDC/SUB/SUBC/CMP. Subtraction is d + ~s + cin,
  // so carry out of 1 means "no borrow".
  // -------------------------------------------------------------------------
  logic              is_sub;
  logic              arith_cin;
  logic [DATA_W-1:0] b_opnd;
  logic [DATA_W:0]   sum_w;
  logic [8:0]        sum_b;
  logic [DATA_W-1:0] arith_res;
  logic              arith_c;
  logic              arith_v;

  always_comb begin
    is_sub    = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
    arith_cin = c_in;
    if (op == OP_ADD) begin
      arith_cin = 1'b0;
    end else if ((op == OP_SUB) || (op == OP_CMP)) begin
      arith_cin = 1'b1;
    end
  end

  assign b_opnd = is_sub ? ~s_val : s_val;
  assign sum_w  = {1'b0, d_val} + {1'b0, b_opnd} + {16'd0, arith_cin};
  assign sum_b  = {1'b0, d_val[7:0]} + {1'b0, b_opnd[7:0]} + {8'd0, arith_cin};

  // Overflow: both addends share a sign that the result does not.
  always_comb begin
    if (byte_mode) begin
      arith_res = {d_val[15:8], sum_b[7:0]};
      arith_c   = sum_b[8];
      arith_v   = (d_val[7] == b_opnd[7]) && (sum_b[7] != d_val[7]);
    end else begin
      arith_res = sum_w[15:0];
      arith_c   = sum_w[16];
      arith_v   = (d_val[15] == b_opnd[15]) && (sum_w[15] != d_val[15]);
    end
  end

  // -------------------------------------------------------------------------
  // Optional BCD adder
  // -------------------------------------------------------------------------
`ifdef ALU_DADD_EN
  logic [DATA_W-1:0] bcd_sum;
  logic              bcd_c;

  xm23_bcd_adder u_bcd (
    .a_i    (d_val),
    .b_i    (s_val),
    .c_i    (c_in),
    .byte_i (byte_mode),
    .sum_o  (bcd_sum),
    .c_o    (bcd_c)
  );
`endif

  // -------------------------------------------------------------------------
  // Operation mux and flag selection.
  //   res_val  : value written to alu_out
  //   flag_val : value Z/N are derived from (differs from res_val for CMP/BIT)
  //   zn_en    : Z/N recomputed; otherwise carried over from psw_in
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] res_val;
  logic [DATA_W-1:0] flag_val;
  logic              zn_en;
  logic              c_new;
  logic              v_new;
  logic              z_new;
  logic              n_new;

  always_comb begin
    res_val  = d_val;
    flag_val = d_val;
    zn_en    = 1'b0;
    c_new    = c_in;
    v_new    = psw_val[PSW_V];

    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        res_val  = arith_res;
        flag_val = arith_res;
        zn_en    = 1'b1;
        c_new    = arith_c;
        v_new    = arith_v;
      end
      OP_CMP: begin
        flag_val = arith_res;
        zn_en    = 1'b1;
        c_new    = arith_c;
        v_new    = arith_v;
      end
      OP_XOR: begin
        res_val  = merge_byte(byte_mode, d_val, d_val ^ s_val);
        flag_val = res_val;
        zn_en    = 1'b1;
        v_new    = 1'b0;
      end
      OP_AND: begin
        res_val  = merge_byte(byte_mode, d_val, d_val & s_val);
        flag_val = res_val;
        zn_en    = 1'b1;
        v_new    = 1'b0;
      end
      OP_OR, OP_BIS: begin
        res_val  = merge_byte(byte_mode, d_val, d_val | s_val);
        flag_val = res_val;
        zn_en    = 1'b1;
        v_new    = 1'b0;
      end
      OP_BIT: begin
        flag_val = merge_byte(byte_mode, d_val, d_val & s_val);
        zn_en    = 1'b1;
        v_new    = 1'b0;
      end
      OP_BIC: begin
        res_val  = merge_byte(byte_mode, d_val, d_val & ~s_val);
        flag_val = res_val;
        zn_en    = 1'b1;
        v_new    = 1'b0;
      end
      OP_MOV: begin
        res_val = merge_byte(byte_mode, d_val, s_val);
      end
      OP_SRA: begin
        res_val  = byte_mode ? {d_val[15:8], d_val[7], d_val[7:1]}
                             : {d_val[15], d_val[15:1]};
        flag_val = res_val;
        zn_en    = 1'b1;
        c_new    = d_val[0];
        v_new    = 1'b0;
      end
      OP_RRC: begin
        res_val  = byte_mode ? {d_val[15:8], c_in, d_val[7:1]}
                             : {c_in, d_val[15:1]};
        flag_val = res_val;
        zn_en    = 1'b1;
        c_new    = d_val[0];
        v_new    = 1'b0;
      end
      OP_SWPB: begin
        res_val  = {d_val[7:0], d_val[15:8]};
        flag_val = res_val;
        zn_en    = 1'b1;
      end
      OP_SXT: begin
        res_val  = {{8{d_val[7]}}, d_val[7:0]};
        flag_val = res_val;
        zn_en    = 1'b1;
      end
`ifdef ALU_DADD_EN
      OP_DADD: begin
        res_val  = merge_byte(byte_mode, d_val, bcd_sum);
        flag_val = res_val;
        zn_en    = 1'b1;
        c_new    = bcd_c;
      end
`endif
      default: begin
        // unsupported codes: d passes through, flags untouched
      end
    endcase
  end

  always_comb begin
    z_new = psw_val[PSW_Z];
    n_new = psw_val[PSW_N];
    if (zn_en) begin
      z_new = byte_mode ? (flag_val[7:0] == 8'd0) : (flag_val == 16'd0);
      n_new = byte_mode ? flag_val[7] : flag_val[15];
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_out_d;
  logic [DATA_W-1:0] alu_out_q;
  logic [DATA_W-1:0] psw_out_d;
  logic [DATA_W-1:0] psw_out_q;

  // Bits outside C/Z/N/V (SLP and the opaque upper bits) always follow psw_in.
  always_comb begin
    alu_out_d = res_val;
    psw_out_d = psw_val;
    if (alu_if.psw_update) begin
      psw_out_d[PSW_C] = c_new;
      psw_out_d[PSW_Z] = z_new;
      psw_out_d[PSW_N] = n_new;
      psw_out_d[PSW_V] = v_new;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      alu_out_q <= '0;
      psw_out_q <= '0;
    end else if (alu_if.alu_E) begin
      alu_out_q <= alu_out_d;
      psw_out_q <= psw_out_d;
    end
  end

  assign alu_if.alu_out = alu_out_q;
  assign alu_if.psw_out = psw_out_q;

endmodule : xm23_alu

// File: tb/tb_xm23_alu.sv
// ---------------------------------------------------------------------------
// tb_xm23_alu
//   Self-checking bench for xm23_alu. Each stimulus pushes its expected
//   result/PSW onto a scoreboard queue; after the next rising edge the entry
//   is popped and compared with the registered outputs.
// ---------------------------------------------------------------------------
module tb_xm23_alu;

  logic clk = 1'b0;
  logic srst;

  always #5 clk = ~clk;

  xm23_alu_if bus ();

  xm23_alu dut (
    .clk_i  (clk),
    .srst_i (srst),
    .alu_if (bus)
  );

  typedef struct {
    logic [15:0] out;
    logic [15:0] psw;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] last_out = 16'h0000;
  logic [15:0] last_psw = 16'h0000;

  // Drive one operation and queue what the registered outputs must become.
  task automatic apply(input logic [5:0] op, input logic [15:0] d, input logic [15:0] s,
                       input logic [15:0] psw, input logic en, input logic upd,
                       input logic [15:0] eo, input logic [15:0] ep, input string nm);
    exp_t e;
    bus.alu_op     = op;
    bus.d_bus      = d;
    bus.s_bus      = s;
    bus.psw_in     = psw;
    bus.alu_E      = en;
    bus.psw_update = upd;
    e.out  = eo;
    e.psw  = ep;
    e.name = nm;
    sb.push_back(e);
    last_out = eo;
    last_psw = ep;
  endtask

  // Independent reference: integer arithmetic over a width mask.
  function automatic logic [31:0] model(input logic [5:0] opf, input logic [15:0] d,
                                        input logic [15:0] s, input logic [15:0] psw,
                                        input logic upd);
    logic [4:0]  o;
    logic        bm, c, z, n, v, zn, keep_d;
    logic [31:0] mask, msb, dl, sl, bo, cy, r, res;
    logic [15:0] out, pso;
    o      = opf[4:0];
    bm     = opf[5] && (o != 5'd15) && (o != 5'd16);
    mask   = bm ? 32'hFF : 32'hFFFF;
    msb    = bm ? 32'h80 : 32'h8000;
    dl     = {16'd0, d} & mask;
    sl     = {16'd0, s} & mask;
    c      = psw[0];
    z      = psw[1];
    n      = psw[2];
    v      = psw[4];
    zn     = 1'b0;
    keep_d = 1'b0;
    res    = dl;
    case (o)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd5: begin
        bo  = (o == 5'd2 || o == 5'd3 || o == 5'd5) ? (~sl & mask) : sl;
        cy  = (o == 5'd0) ? 32'd0 : ((o == 5'd2 || o == 5'd5) ? 32'd1 : {31'd0, c});
        r   = dl + bo + cy;
        res = r & mask;
        c   = (r > mask);
        v   = ((~(dl ^ bo)) & (dl ^ res) & msb) != 32'd0;
        zn  = 1'b1;
        keep_d = (o == 5'd5);
      end
      5'd6:         begin res = dl ^ sl;         v = 1'b0; zn = 1'b1; end
      5'd7:         begin res = dl & sl;         v = 1'b0; zn = 1'b1; end
      5'd8, 5'd11:  begin res = dl | sl;         v = 1'b0; zn = 1'b1; end
      5'd9:         begin res = dl & sl;         v = 1'b0; zn = 1'b1; keep_d = 1'b1; end
      5'd10:        begin res = dl & ~sl & mask; v = 1'b0; zn = 1'b1; end
      5'd12:        res = sl;
      5'd13: begin res = (dl >> 1) | (dl & msb); c = dl[0]; v = 1'b0; zn = 1'b1; end
      5'd14: begin res = (dl >> 1) | (c ? msb : 32'd0); c = dl[0]; v = 1'b0; zn = 1'b1; end
      5'd15: begin res = {16'd0, d[7:0], d[15:8]}; zn = 1'b1; end
      5'd16: begin res = {16'd0, {8{d[7]}}, d[7:0]}; zn = 1'b1; end
`ifdef ALU_DADD_EN
      5'd4: begin
        cy  = {31'd0, c};
        res = 32'd0;
        for (int k = 0; k < (bm ? 2 : 4); k++) begin
          r = ((dl >> (4*k)) & 32'hF) + ((sl >> (4*k)) & 32'hF) + cy;
          if (r > 32'd9) begin
            r  = r + 32'd6;
            cy = 32'd1;
          end else begin
            cy = 32'd0;
          end
          res = res | ((r & 32'hF) << (4*k));
        end
        c  = cy[0];
        zn = 1'b1;
      end
`endif
      default: ;
    endcase
    if (zn) begin
      z = ((res & mask) == 32'd0);
      n = ((res & msb) != 32'd0);
    end
    out = keep_d ? d : ((d & ~mask[15:0]) | res[15:0]);
    pso = upd ? {psw[15:5], v, psw[3], n, z, c} : psw;
    return {out, pso};
  endfunction

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin srst = 1'b1; apply(6'h00, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, "reset_add"); end
        1: begin srst = 1'b0; apply(6'h00, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h0000, "post_reset_add"); end
        2: begin srst = 1'b1; apply(6'h00, 16'h7FFF, 16'h0001, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'h0000, "reset_over_load"); end
        default: ;
      endcase
      @(posedge clk); #1;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL reset scoreboard empty got=%h required=queued entry", bus.alu_out);
      end else begin
        e = sb.pop_front();
        if (bus.alu_out !== e.out || bus.psw_out !== e.psw)
          $display("FAIL %s out=%h psw=%h required out=%h psw=%h", e.name, bus.alu_out, bus.psw_out, e.out, e.psw);
        else begin
          n_pass++;
          $display("ok   %s out=%h psw=%h", e.name, bus.alu_out, bus.psw_out);
        end
      end
    end
    srst = 1'b0;
  endtask

  task automatic test_word_ops();
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      case (i)
        0:  apply(6'h00, 16'h7FFF, 16'h0001, 16'h60E0, 1'b1, 1'b1, 16'h8000, 16'h60F4, "add_ovf");
        1:  apply(6'h02, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0003, "sub_zero");
        2:  apply(6'h05, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h0005, 16'h0003, "cmp_eq");
        3:  apply(6'h00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0003, "add_wrap");
        4:  apply(6'h03, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'h0001, "subc_c0");
        5:  apply(6'h01, 16'h0001, 16'h0001, 16'h0001, 1'b1, 1'b1, 16'h0003, 16'h0000, "addc_c1");
        6:  apply(6'h07, 16'hF0F0, 16'hFF00, 16'h0011, 1'b1, 1'b1, 16'hF000, 16'h0005, "and");
        7:  apply(6'h09, 16'h00F0, 16'h0F00, 16'h0000, 1'b1, 1'b1, 16'h00F0, 16'h0002, "bit");
        8:  apply(6'h0A, 16'hFFFF, 16'h00FF, 16'h0010, 1'b1, 1'b1, 16'hFF00, 16'h0004, "bic");
        9:  apply(6'h0C, 16'hAAAA, 16'h1234, 16'h0017, 1'b1, 1'b1, 16'h1234, 16'h0017, "mov");
        10: apply(6'h02, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 16'h0011, "sub_ovf");
        11: apply(6'h06, 16'hAAAA, 16'hAAAA, 16'h0004, 1'b1, 1'b1, 16'h0000, 16'h0002, "xor_zero");
        12: apply(6'h0B, 16'h0100, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0101, 16'h0000, "bis");
        default: ;
      endcase
      @(posedge clk); #1;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL word scoreboard empty got=%h required=queued entry", bus.alu_out);
      end else begin
        e = sb.pop_front();
        if (bus.alu_out !== e.out || bus.psw_out !== e.psw)
          $display("FAIL %s out=%h psw=%h required out=%h psw=%h", e.name, bus.alu_out, bus.psw_out, e.out, e.psw);
        else begin
          n_pass++;
          $display("ok   %s out=%h psw=%h", e.name, bus.alu_out, bus.psw_out);
        end
      end
    end
  endtask

  task automatic test_byte_mode();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: apply(6'h20, 16'h12FF, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h1200, 16'h0003, "addb_wrap");
        1: apply(6'h20, 16'hAB7F, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'hAB80, 16'h0014, "addb_ovf");
        2: apply(6'h22, 16'h5500, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h55FF, 16'h0004, "subb_borrow");
        3: apply(6'h2F, 16'h12F4, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hF412, 16'h0004, "swpb_bytebit");
        4: apply(6'h30, 16'h1280, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFF80, 16'h0004, "sxt_bytebit");
        5: apply(6'h2C, 16'hAAAA, 16'h1234, 16'h0003, 1'b1, 1'b1, 16'hAA34, 16'h0003, "movb");
        6: apply(6'h2D, 16'h1281, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h12C0, 16'h0005, "srab");
        default: ;
      endcase
      @(posedge clk); #1;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL byte scoreboard empty got=%h required=queued entry", bus.alu_out);
      end else begin
        e = sb.pop_front();
        if (bus.alu_out !== e.out || bus.psw_out !== e.psw)
          $display("FAIL %s out=%h psw=%h required out=%h psw=%h", e.name, bus.alu_out, bus.psw_out, e.out, e.psw);
        else begin
          n_pass++;
          $display("ok   %s out=%h psw=%h", e.name, bus.alu_out, bus.psw_out);
        end
      end
    end
  endtask

  task automatic test_shift_bcd();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: apply(6'h0E, 16'h0001, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'h8000, 16'h0005, "rrc_c1");
        1: apply(6'h0D, 16'h8003, 16'h0000, 16'h0010, 1'b1, 1'b1, 16'hC001, 16'h0005, "sra");
        2: apply(6'h2E, 16'hFF02, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFF81, 16'h0004, "rrcb");
`ifdef ALU_DADD_EN
        3: apply(6'h04, 16'h0999, 16'h0001, 16'h0016, 1'b1, 1'b1, 16'h1000, 16'h0010, "dadd_ripple");
        4: apply(6'h04, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0003, "dadd_wrap");
        5: apply(6'h24, 16'h1299, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h1200, 16'h0003, "daddb_wrap");
`else
        3: apply(6'h04, 16'h0999, 16'h0001, 16'h0016, 1'b1, 1'b1, 16'h0999, 16'h0016, "dadd_off");
        4: apply(6'h04, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h9999, 16'h0000, "dadd_off2");
        5: apply(6'h24, 16'h1299, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h1299, 16'h0000, "daddb_off");
`endif
        6: apply(6'h15, 16'hBEEF, 16'h1111, 16'h00FF, 1'b1, 1'b1, 16'hBEEF, 16'h00FF, "unsupported");
        default: ;
      endcase
      @(posedge clk); #1;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL shift scoreboard empty got=%h required=queued entry", bus.alu_out);
      end else begin
        e = sb.pop_front();
        if (bus.alu_out !== e.out || bus.psw_out !== e.psw)
          $display("FAIL %s out=%h psw=%h required out=%h psw=%h", e.name, bus.alu_out, bus.psw_out, e.out, e.psw);
        else begin
          n_pass++;
          $display("ok   %s out=%h psw=%h", e.name, bus.alu_out, bus.psw_out);
        end
      end
    end
  endtask

  task automatic test_psw_hold();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: apply(6'h02, 16'h0000, 16'h0001, 16'h1234, 1'b1, 1'b0, 16'hFFFF, 16'h1234, "no_psw_update");
        1: apply(6'h00, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h1234, "hold_1");
        2: apply(6'h07, 16'h5555, 16'h00FF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 16'h1234, "hold_2");
        3: apply(6'h00, 16'h0001, 16'h0001, 16'hFFEF, 1'b1, 1'b1, 16'h0002, 16'hFFE8, "opaque_bits");
        default: ;
      endcase
      @(posedge clk); #1;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL hold scoreboard empty got=%h required=queued entry", bus.alu_out);
      end else begin
        e = sb.pop_front();
        if (bus.alu_out !== e.out || bus.psw_out !== e.psw)
          $display("FAIL %s out=%h psw=%h required out=%h psw=%h", e.name, bus.alu_out, bus.psw_out, e.out, e.psw);
        else begin
          n_pass++;
          $display("ok   %s out=%h psw=%h", e.name, bus.alu_out, bus.psw_out);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [5:0]  op;
    logic [15:0] d, s, psw;
    logic        en, upd;
    logic [31:0] m;
    for (int i = 0; i < 120; i++) begin
      op  = 6'($urandom_range(0, 63));
      d   = 16'($urandom);
      s   = 16'($urandom);
      psw = 16'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      upd = 1'($urandom_range(0, 1));
      m   = model(op, d, s, psw, upd);
      if (en)
        apply(op, d, s, psw, en, upd, m[31:16], m[15:0], $sformatf("rand%0d_op%02h", i, op));
      else
        apply(op, d, s, psw, en, upd, last_out, last_psw, $sformatf("rand%0d_hold", i));
      @(posedge clk); #1;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL random scoreboard empty got=%h required=queued entry", bus.alu_out);
      end else begin
        e = sb.pop_front();
        if (bus.alu_out !== e.out || bus.psw_out !== e.psw)
          $display("FAIL %s d=%h s=%h psw_in=%h out=%h psw=%h required out=%h psw=%h",
                   e.name, d, s, psw, bus.alu_out, bus.psw_out, e.out, e.psw);
        else begin
          n_pass++;
          $display("ok   %s out=%h psw=%h", e.name, bus.alu_out, bus.psw_out);
        end
      end
    end
  endtask

  initial begin
    srst           = 1'b1;
    bus.alu_op     = 6'h00;
    bus.d_bus      = 16'h0000;
    bus.s_bus      = 16'h0000;
    bus.psw_in     = 16'h0000;
    bus.alu_E      = 1'b0;
    bus.psw_update = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_word_ops();
    test_byte_mode();
    test_shift_bcd();
    test_psw_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d required=run to completion", n_pass);
    $fatal(1, "watchdog");
  end

endmodule : tb_xm23_alu
